alu_issue: RTL and testbench

Issue/retire controller directly upstream of the integer ALU (mini-ALU, multiplier, divider). Accepts one decoded instruction at a time over a valid/ready handshake and registers its operands. It pulses `alu_req` and holds all operand and control inputs of the ALU stable until the ALU's variable-latency result returns. It then presents the result to the writeback stage through a registered valid/ready port, with flush and timeout handling.

---
 rtl/alu_issue.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/retire controller in front of the integer ALU; req 1 cycle after accept, wb_valid 1 cycle after alu_wb_vld.
// Backpressure: one instruction in flight, in_ready only in IDLE, result held in HOLD until wb_ready or flush.
package alu_issue_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } opType;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_rem;
        logic is_signed;
        logic is_word;
        logic use_imm;
    } InstAct;
endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int TIMEOUT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  opType       in_op,
    input  InstAct      in_inst_act,
    input  logic [4:0]  in_dst_id,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_pc,
    input  logic        flush,
    output logic        alu_req,
    output opType       alu_op,
    output InstAct      alu_inst_act,
    output logic [4:0]  alu_dst_id,
    output logic [63:0] alu_src1,
    output logic [63:0] alu_src2,
    output logic [63:0] alu_imm,
    output logic [63:0] alu_pc,
    input  logic        alu_wb_vld,
    input  logic [63:0] alu_wb_data,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [63:0] wb_data,
    output logic        err_timeout,
    output logic [31:0] ops_done
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

    state_t      state_q, state_d;
    opType       op_q;
    InstAct      act_q;
    logic [4:0]  dst_q;
    logic [63:0] src1_q, src2_q, imm_q, pc_q;
    logic [63:0] wb_data_q;
    logic [4:0]  wb_addr_q;
    logic        wb_we_q;
    logic        err_q, err_d;
    logic [31:0] ops_q;
    logic [9:0]  tmo_q, tmo_d;
    logic [9:0]  tmo_inc;
    logic        accept, capture, retire;

    assign tmo_inc = tmo_q + 10'd1;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        accept  = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    tmo_d   = 10'd0;
                end
            end
            S_WAIT: begin
                if (alu_wb_vld) begin
                    capture = !flush;
                    state_d = flush ? S_IDLE : S_HOLD;
                end else if (tmo_inc == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    // Long ops cannot be cancelled, so wait out the result
                    if (flush) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (alu_wb_vld) begin
                    state_d = S_IDLE;
                end else if (tmo_inc == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_HOLD: begin
                if (wb_ready) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= opType'(4'd0);
            act_q     <= '0;
            dst_q     <= 5'd0;
            src1_q    <= 64'd0;
            src2_q    <= 64'd0;
            imm_q     <= 64'd0;
            pc_q      <= 64'd0;
            wb_data_q <= 64'd0;
            wb_addr_q <= 5'd0;
            wb_we_q   <= 1'b0;
            err_q     <= 1'b0;
            ops_q     <= 32'd0;
            tmo_q     <= 10'd0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            // Divider muxes its result off act_q, so operands move only on accept
            if (accept) begin
                op_q   <= in_op;
                act_q  <= in_inst_act;
                dst_q  <= in_dst_id;
                src1_q <= in_src1;
                src2_q <= in_src2;
                imm_q  <= in_imm;
                pc_q   <= in_pc;
            end
            if (capture) begin
                wb_data_q <= alu_wb_data;
                wb_addr_q <= dst_q;
                wb_we_q   <= (dst_q != 5'd0);
            end
            if (retire) ops_q <= ops_q + 32'd1;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign alu_req      = (state_q == S_ISSUE) && !flush;
    assign wb_valid     = (state_q == S_HOLD);
    assign alu_op       = op_q;
    assign alu_inst_act = act_q;
    assign alu_dst_id   = dst_q;
    assign alu_src1     = src1_q;
    assign alu_src2     = src2_q;
    assign alu_imm      = imm_q;
    assign alu_pc       = pc_q;
    assign wb_we        = wb_we_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign err_timeout  = err_q;
    assign ops_done     = ops_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: main instance at default TIMEOUT, second instance at TIMEOUT=8.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, alu_wb_vld, wb_ready;
    opType       in_op;
    InstAct      in_inst_act;
    logic [4:0]  in_dst_id;
    logic [63:0] in_src1, in_src2, in_imm, in_pc, alu_wb_data;

    logic        in_ready, alu_req, wb_valid, wb_we, err_timeout;
    opType       alu_op;
    InstAct      alu_inst_act;
    logic [4:0]  alu_dst_id, wb_addr;
    logic [63:0] alu_src1, alu_src2, alu_imm, alu_pc, wb_data;
    logic [31:0] ops_done;

    logic        in_ready_t, alu_req_t, wb_valid_t, wb_we_t, err_timeout_t;
    opType       alu_op_t;
    InstAct      alu_inst_act_t;
    logic [4:0]  alu_dst_id_t, wb_addr_t;
    logic [63:0] alu_src1_t, alu_src2_t, alu_imm_t, alu_pc_t, wb_data_t;
    logic [31:0] ops_done_t;

    int n_vec = 0;
    int n_err = 0;

    localparam InstAct ACT_NONE = 6'b000000;
    localparam InstAct ACT_IMM  = 6'b000001;
    localparam InstAct ACT_MUL  = 6'b100100;
    localparam InstAct ACT_DIV  = 6'b010100;
    localparam InstAct ACT_JUNK = 6'b111111;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_inst_act(in_inst_act), .in_dst_id(in_dst_id),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_pc(in_pc),
        .flush(flush), .alu_req(alu_req), .alu_op(alu_op), .alu_inst_act(alu_inst_act),
        .alu_dst_id(alu_dst_id), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_wb_vld(alu_wb_vld),
        .alu_wb_data(alu_wb_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .err_timeout(err_timeout), .ops_done(ops_done)
    );

    alu_issue #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_op(in_op), .in_inst_act(in_inst_act), .in_dst_id(in_dst_id),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_pc(in_pc),
        .flush(flush), .alu_req(alu_req_t), .alu_op(alu_op_t), .alu_inst_act(alu_inst_act_t),
        .alu_dst_id(alu_dst_id_t), .alu_src1(alu_src1_t), .alu_src2(alu_src2_t),
        .alu_imm(alu_imm_t), .alu_pc(alu_pc_t), .alu_wb_vld(alu_wb_vld),
        .alu_wb_data(alu_wb_data), .wb_valid(wb_valid_t), .wb_ready(wb_ready),
        .wb_we(wb_we_t), .wb_addr(wb_addr_t), .wb_data(wb_data_t),
        .err_timeout(err_timeout_t), .ops_done(ops_done_t)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input opType op, input InstAct act, input logic [4:0] dst,
                         input logic [63:0] s1, input logic [63:0] s2,
                         input logic [63:0] imm, input logic [63:0] pc);
        in_valid = 1'b1; in_op = op; in_inst_act = act; in_dst_id = dst;
        in_src1 = s1; in_src2 = s2; in_imm = imm; in_pc = pc;
    endtask

    // Accept in T, ALU answers in T+2; returns positioned in T+3 (HOLD).
    task automatic to_hold(input opType op, input InstAct act, input logic [4:0] dst,
                           input logic [63:0] s1, input logic [63:0] imm, input logic [63:0] res);
        issue(op, act, dst, s1, 64'd0, imm, 64'h1000);
        #1 chk("accept_in_ready", in_ready, 1'b1);
        chk("accept_no_req", alu_req, 1'b0);
        step();
        in_valid = 1'b0;
        #1 chk("issue_req", alu_req, 1'b1);
        chk("issue_dst", alu_dst_id, dst);
        chk("issue_src1", alu_src1, s1);
        chk("issue_imm", alu_imm, imm);
        step();
        alu_wb_vld = 1'b1; alu_wb_data = res;
        #1 chk("wait_req_low", alu_req, 1'b0);
        chk("wait_no_wbv", wb_valid, 1'b0);
        step();
        alu_wb_vld = 1'b0;
    endtask

    task automatic mini(input opType op, input logic [4:0] dst, input logic [63:0] s1,
                        input logic [63:0] imm, input logic [63:0] res, input logic exp_we,
                        input logic [31:0] exp_ops);
        to_hold(op, ACT_IMM, dst, s1, imm, res);
        wb_ready = 1'b1;
        #1 chk("hold_wbv", wb_valid, 1'b1);
        chk("hold_we", wb_we, exp_we);
        chk("hold_addr", wb_addr, dst);
        chk("hold_data", wb_data, res);
        step();
        wb_ready = 1'b0;
        #1 chk("retire_ops", ops_done, exp_ops);
        chk("retire_idle", in_ready, 1'b1);
        chk("retire_wbv_low", wb_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_wb_vld = 1'b0; wb_ready = 1'b0;
        in_op = OP_ADD; in_inst_act = ACT_NONE; in_dst_id = 5'd0;
        in_src1 = 64'd0; in_src2 = 64'd0; in_imm = 64'd0; in_pc = 64'd0; alu_wb_data = 64'd0;
        step(); step();
        #1 chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req", alu_req, 1'b0);
        chk("rst_wbv", wb_valid, 1'b0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_ops", ops_done, 32'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_addr", wb_addr, 5'd0);
        chk("rst_src1", alu_src1, 64'd0);
        rst_n = 1'b1;

        // addi x3 = 5 + 7
        mini(OP_ADDI, 5'd3, 64'd5, 64'd7, 64'd12, 1'b1, 32'd1);

        // stray ALU pulse in IDLE
        alu_wb_vld = 1'b1; alu_wb_data = 64'd99;
        step();
        alu_wb_vld = 1'b0;
        #1 chk("stray_wbv", wb_valid, 1'b0);
        chk("stray_data", wb_data, 64'd12);

        // div with ALU answer at T+40 and 5 cycles of writeback backpressure
        issue(OP_DIV, ACT_DIV, 5'd7, 64'd100, 64'd7, 64'd0, 64'h2000);
        step();
        issue(OP_ADD, ACT_JUNK, 5'd9, 64'd55, 64'd1, 64'd1, 64'h3000);
        #1 chk("div_req", alu_req, 1'b1);
        chk("div_act", alu_inst_act, ACT_DIV);
        step();
        for (int i = 2; i < 40; i++) begin
            #1 chk("div_act_stable", alu_inst_act, ACT_DIV);
            chk("div_src1_stable", alu_src1, 64'd100);
            chk("div_busy", in_ready, 1'b0);
            chk("div_req_low", alu_req, 1'b0);
            step();
        end
        in_valid = 1'b0; alu_wb_vld = 1'b1; alu_wb_data = 64'd14;
        #1 chk("div_no_wbv_yet", wb_valid, 1'b0);
        step();
        alu_wb_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_wbv", wb_valid, 1'b1);
            chk("bp_data", wb_data, 64'd14);
            chk("bp_addr", wb_addr, 5'd7);
            chk("bp_act", alu_inst_act, ACT_DIV);
            step();
        end
        wb_ready = 1'b1;
        #1 chk("bp_release_wbv", wb_valid, 1'b1);
        step();
        wb_ready = 1'b0;
        #1 chk("div_ops", ops_done, 32'd2);
        chk("div_wbv_low", wb_valid, 1'b0);

        // x0 destination
        mini(OP_ADD, 5'd0, 64'd1, 64'd2, 64'd3, 1'b0, 32'd3);

        // flush a multiply in WAIT at T+3, ALU answers at T+10
        issue(OP_MUL, ACT_MUL, 5'd9, 64'd6, 64'd7, 64'd0, 64'h4000);
        step();
        in_valid = 1'b0;
        #1 chk("mul_req", alu_req, 1'b1);
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 4; i < 10; i++) begin
            #1 chk("drain_busy", in_ready, 1'b0);
            chk("drain_wbv", wb_valid, 1'b0);
            step();
        end
        alu_wb_vld = 1'b1; alu_wb_data = 64'd42;
        step();
        alu_wb_vld = 1'b0;
        #1 chk("drain_done_ready", in_ready, 1'b1);
        chk("drain_done_wbv", wb_valid, 1'b0);
        mini(OP_ADDI, 5'd4, 64'd10, 64'd20, 64'd30, 1'b1, 32'd4);

        // flush in ISSUE
        issue(OP_ADD, ACT_NONE, 5'd5, 64'd1, 64'd1, 64'd0, 64'h5000);
        step();
        in_valid = 1'b0; flush = 1'b1;
        #1 chk("issue_flush_req", alu_req, 1'b0);
        step();
        flush = 1'b0;
        #1 chk("issue_flush_idle", in_ready, 1'b1);
        chk("issue_flush_wbv", wb_valid, 1'b0);

        // flush coincident with ALU result in WAIT
        issue(OP_ADD, ACT_NONE, 5'd6, 64'd2, 64'd2, 64'd0, 64'h6000);
        step();
        in_valid = 1'b0;
        #1 chk("cofl_req", alu_req, 1'b1);
        step();
        alu_wb_vld = 1'b1; alu_wb_data = 64'd4; flush = 1'b1;
        step();
        alu_wb_vld = 1'b0; flush = 1'b0;
        #1 chk("cofl_idle", in_ready, 1'b1);
        chk("cofl_wbv", wb_valid, 1'b0);
        chk("cofl_data_kept", wb_data, 64'd30);
        chk("cofl_ops", ops_done, 32'd4);

        // flush in IDLE blocks acceptance
        issue(OP_ADD, ACT_NONE, 5'd8, 64'd77, 64'd0, 64'd0, 64'h7000);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        #1 chk("idle_flush_ready", in_ready, 1'b1);
        chk("idle_flush_req", alu_req, 1'b0);
        chk("idle_flush_src1", alu_src1, 64'd2);

        // HOLD: wb_ready beats flush, then flush alone drops
        to_hold(OP_ADDI, ACT_IMM, 5'd10, 64'd3, 64'd4, 64'd7);
        flush = 1'b1; wb_ready = 1'b1;
        #1 chk("hold_race_wbv", wb_valid, 1'b1);
        step();
        flush = 1'b0; wb_ready = 1'b0;
        #1 chk("hold_race_ops", ops_done, 32'd5);
        to_hold(OP_ADDI, ACT_IMM, 5'd11, 64'd1, 64'd1, 64'd2);
        flush = 1'b1;
        #1 chk("hold_flush_wbv", wb_valid, 1'b1);
        step();
        flush = 1'b0;
        #1 chk("hold_flush_ops", ops_done, 32'd5);
        chk("hold_flush_idle", in_ready, 1'b1);
        chk("hold_flush_wbv_low", wb_valid, 1'b0);

        // timeout on the TIMEOUT=8 instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1 chk("to_rst_err", err_timeout_t, 1'b0);
        chk("to_rst_ops", ops_done_t, 32'd0);
        issue(OP_DIV, ACT_DIV, 5'd12, 64'd1, 64'd0, 64'd0, 64'h8000);
        step();
        in_valid = 1'b0;
        #1 chk("to_req", alu_req_t, 1'b1);
        step();
        for (int i = 2; i < 10; i++) begin
            #1 chk("to_err_early", err_timeout_t, 1'b0);
            chk("to_busy", in_ready_t, 1'b0);
            step();
        end
        #1 chk("to_err_set", err_timeout_t, 1'b1);
        chk("to_ready", in_ready_t, 1'b1);
        chk("to_no_wbv", wb_valid_t, 1'b0);
        step(); step(); step();
        #1 chk("to_sticky", err_timeout_t, 1'b1);

        // reset mid-WAIT on the main instance, then a late ALU pulse
        chk("main_still_wait", in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1 chk("to_err_cleared", err_timeout_t, 1'b0);
        chk("main_rst_idle", in_ready, 1'b1);
        chk("main_rst_ops", ops_done, 32'd0);
        alu_wb_vld = 1'b1; alu_wb_data = 64'd5;
        step();
        alu_wb_vld = 1'b0;
        #1 chk("late_vld_wbv", wb_valid, 1'b0);
        chk("late_vld_data", wb_data, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
